led_pattern_gen: RTL and testbench
==================================

# led_pattern_gen

Parametrised LED pattern generator for the DE2 board demos: an internal prescaler divides CLK down to a step tick, and each tick advances a WIDTH-bit LED register through one of four selectable patterns: Johnson fill, rotate, ping-pong and binary count. It supports direction control, run/pause, and a synchronous parallel load from the switches. It drives LEDR directly and exports tick and wrap pulses for chaining or for triggering other demo logic.

## Interface
- WIDTH, 18: LED register width; minimum 2.
- DIV, 25_000_000: prescaler period in CLK cycles; minimum 1.
- CNT_W, 25: prescaler counter width; must satisfy 2^CNT_W >= DIV.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- EN  in  1  run enable; 0 freezes the prescaler and the pattern.
- MODE  in  2  pattern select: 0 Johnson, 1 rotate, 2 ping-pong, 3 counter.
- DIR  in  1  direction: 0 toward MSB (count up), 1 toward LSB (count down).
- LOAD  in  1  synchronous parallel load strobe.
- LOAD_VAL  in  WIDTH  value written on LOAD.
- LED  out  WIDTH  registered pattern.
- TICK  out  1  registered one-cycle pulse, high in the cycle LED shows a new step.
- WRAP  out  1  registered one-cycle pulse coincident with TICK when a pattern cycle completes.

## Operation
- Reset (RST=0, async): LED=0, TICK=0, WRAP=0, prescaler=0, mode_q=0, bounce direction=up.
- Priority per edge: reset > LOAD > mode change > step.
- LOAD=1:
  - LED<=LOAD_VAL; prescaler<=0; bounce direction<=DIR; mode_q<=MODE.
  - TICK=WRAP=0.
  - LOAD acts regardless of EN.
- Mode change (MODE != mode_q, no LOAD):
  - mode_q<=MODE; prescaler<=0; LED<=seed; bounce direction<=DIR; no TICK.
  - Seeds: Johnson 0, rotate 1, counter 0, ping-pong 1 if DIR=0 else 1<<(WIDTH-1).
- Prescaler: counts 0..DIV-1 while EN=1. When the count is DIV-1 with EN=1, a step occurs on that edge and the count returns to 0. EN=0 holds the count.
- Step rules, DIR=0 (DIR=1 is the mirror):
  - Johnson: LED<={LED[WIDTH-2:0], ~LED[WIDTH-1]}. WRAP when the next value is all zeros. Period 2*WIDTH steps.
  - Rotate: LED<={LED[WIDTH-2:0], LED[WIDTH-1]}. WRAP when the bit rotated out is 1.
  - Counter: LED<=LED+1 (DIR=1: LED-1), modulo 2^WIDTH. WRAP on overflow 2^WIDTH-1→0 (underflow 0→2^WIDTH-1).
  - Ping-pong:
    - Uses the internal bounce direction; DIR is used only at entry/LOAD.
    - Moving up: if LED[WIDTH-1]=1, reverse and shift right this step. Otherwise shift left with zero fill.
    - Moving down: the mirror rule at LED[0]. WRAP on the step that reverses at the LSB end.
    - If LED==0 at a step, reseed to 1 with direction up, and no WRAP.
- DIR changes in modes 0/1/3 take effect at the next step; the pattern is not reseeded.

## Timing
- LED, TICK, and WRAP are registered, with no combinational input-to-output paths.
- A step edge updates LED, and TICK is high for exactly that following cycle. WRAP is high in the same cycle when applicable.
- Step period is DIV cycles while EN stays 1. With DIV=1, TICK is high every cycle.
- After LOAD or a mode change, the first step occurs DIV cycles later.
- EN deasserted mid-count: the step is delayed by exactly the number of cycles EN was low.
- LOAD in the same cycle as a pending step: LOAD wins, the step is discarded, and the prescaler restarts.
- Reset mid-operation: outputs clear immediately (async). The first step occurs DIV cycles after RST deasserts with EN=1.

## Test plan
- WIDTH=4, DIV=3, MODE=0, DIR=0, EN=1 after reset:
  - LED steps 0001,0011,0111,1111,1110,1100,1000,0000 at 3-cycle spacing.
  - TICK pulses one cycle each; WRAP only with 0000.
- MODE=2, DIR=0, WIDTH=4, DIV=1:
  - LED 0001 (seed), then 0010,0100,1000,0100,0010,0001,0010.
  - WRAP on the step to 0010 after 0001.
- MODE=3, DIR=1, LOAD with LOAD_VAL=0001, DIV=2:
  - LED 0001, then 0000 then 1111.
  - WRAP with 1111 only.
- EN: with EN=0 for 5 cycles mid-count, DIV=3, the next TICK arrives 5 cycles late and LED holds. LOAD=1, LOAD_VAL=1010 during EN=0 gives LED=1010 on the next edge.
- LOAD asserted on the same edge as a due step: LED=LOAD_VAL, no TICK, and the next TICK occurs DIV cycles later.
- RST pulled low mid-sequence between edges: LED=0 and TICK=WRAP=0 immediately. After release, the first step lands DIV cycles later with the mode seed sequence.

Source files
------------

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
//
// LED pattern generator for the DE2 demos. A prescaler divides CLK down to a
// step tick; each tick advances a WIDTH-bit LED register through the pattern
// selected by MODE (Johnson fill, rotate, ping-pong, binary counter).
// A parallel load from the switches and a change of MODE both restart the
// prescaler, so the first step after either lands DIV cycles later.
//
// Parameters
//   WIDTH    LED register width (>= 2)
//   DIV      prescaler period in CLK cycles (>= 1)
//   CNT_W    prescaler counter width, 2**CNT_W >= DIV
//
// Ports
//   CLK       in   system clock, rising edge
//   RST       in   asynchronous reset, active low
//   EN        in   run enable; low freezes prescaler and pattern
//   MODE      in   0 Johnson, 1 rotate, 2 ping-pong, 3 counter
//   DIR       in   0 toward MSB / count up, 1 toward LSB / count down
//   LOAD      in   synchronous parallel load strobe (acts regardless of EN)
//   LOAD_VAL  in   value written to LED on LOAD
//   LED       out  registered pattern
//   TICK      out  one-cycle pulse in the cycle LED shows a new step
//   WRAP      out  one-cycle pulse with TICK when a pattern cycle completes
// ---------------------------------------------------------------------------
module led_pattern_gen #(
  parameter int WIDTH = 18,
  parameter int DIV   = 25_000_000,
  parameter int CNT_W = 25
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             DIR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] LED,
  output logic             TICK,
  output logic             WRAP
);

  // Ping-pong bounce direction
  //   state     | meaning
  //   BOUNCE_UP | lit bits travel toward the MSB
  //   BOUNCE_DN | lit bits travel toward the LSB
  typedef enum logic {
    BOUNCE_UP = 1'b0,
    BOUNCE_DN = 1'b1
  } bounce_t;

  localparam logic [1:0] MODE_JOHNSON  = 2'd0;
  localparam logic [1:0] MODE_ROTATE   = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;
  localparam logic [1:0] MODE_COUNTER  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [WIDTH-1:0] LSB_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_ONE  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  bounce_t          bounce_q, bounce_d;
  logic [WIDTH-1:0] led_d;
  logic             tick_d, wrap_d;

  logic [WIDTH-1:0] step_led;
  logic             step_wrap;
  bounce_t          step_bounce;
  logic [WIDTH-1:0] seed_led;
  bounce_t          dir_bounce;
  logic             step_due;
  logic             mode_chg;

  assign step_due   = EN && (cnt_q == CNT_LAST);
  assign mode_chg   = (MODE != mode_q);
  assign dir_bounce = DIR ? BOUNCE_DN : BOUNCE_UP;

  // Value the LED register takes on entry to MODE.
  always_comb begin
    seed_led = '0;
    case (MODE)
      MODE_JOHNSON:  seed_led = '0;
      MODE_ROTATE:   seed_led = LSB_ONE;
      MODE_PINGPONG: seed_led = DIR ? MSB_ONE : LSB_ONE;
      MODE_COUNTER:  seed_led = '0;
    endcase
  end

  // Next pattern value for one step of the current mode.
  always_comb begin
    step_led    = LED;
    step_wrap   = 1'b0;
    step_bounce = bounce_q;
    case (mode_q)
      MODE_JOHNSON: begin
        step_led  = DIR ? {~LED[0], LED[WIDTH-1:1]}
                        : {LED[WIDTH-2:0], ~LED[WIDTH-1]};
        step_wrap = (step_led == '0);
      end
      MODE_ROTATE: begin
        step_led  = DIR ? {LED[0], LED[WIDTH-1:1]}
                        : {LED[WIDTH-2:0], LED[WIDTH-1]};
        // wrap flags the bit that falls off the end and re-enters
        step_wrap = DIR ? LED[0] : LED[WIDTH-1];
      end
      MODE_COUNTER: begin
        step_led  = DIR ? (LED - LSB_ONE) : (LED + LSB_ONE);
        step_wrap = DIR ? (LED == '0) : (&LED);
      end
      MODE_PINGPONG: begin
        if (LED == '0) begin
          // nothing lit would never move again; restart from the LSB
          step_led    = LSB_ONE;
          step_bounce = BOUNCE_UP;
        end else if (bounce_q == BOUNCE_UP) begin
          if (LED[WIDTH-1]) begin
            step_led    = LED >> 1;
            step_bounce = BOUNCE_DN;
          end else begin
            step_led = LED << 1;
          end
        end else begin
          if (LED[0]) begin
            step_led    = LED << 1;
            step_bounce = BOUNCE_UP;
            step_wrap   = 1'b1;
          end else begin
            step_led = LED >> 1;
          end
        end
      end
    endcase
  end

  // Priority: LOAD > mode change > step.
  always_comb begin
    led_d    = LED;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    bounce_d = bounce_q;
    tick_d   = 1'b0;
    wrap_d   = 1'b0;
    if (LOAD) begin
      led_d    = LOAD_VAL;
      cnt_d    = '0;
      mode_d   = MODE;
      bounce_d = dir_bounce;
    end else if (mode_chg) begin
      led_d    = seed_led;
      cnt_d    = '0;
      mode_d   = MODE;
      bounce_d = dir_bounce;
    end else if (step_due) begin
      led_d    = step_led;
      cnt_d    = '0;
      bounce_d = step_bounce;
      tick_d   = 1'b1;
      wrap_d   = step_wrap;
    end else if (EN) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      LED      <= '0;
      TICK     <= 1'b0;
      WRAP     <= 1'b0;
      cnt_q    <= '0;
      mode_q   <= MODE_JOHNSON;
      bounce_q <= BOUNCE_UP;
    end else begin
      LED      <= led_d;
      TICK     <= tick_d;
      WRAP     <= wrap_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      bounce_q <= bounce_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_gen
//
// Two 4-bit generators (DIV=3 and DIV=1) share one set of inputs. Each is
// compared every cycle against a behavioural model that tracks the LED value
// as an integer and applies the pattern rules with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       dir;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] led_a, led_b;
  logic       tick_a, tick_b, wrap_a, wrap_b;

  int n_checks = 0;
  int n_fail   = 0;

  // model state, index 0 = DIV 3, index 1 = DIV 1
  int m_led  [2];
  int m_cnt  [2];
  int m_mode [2];
  bit m_up   [2];
  bit m_tick [2];
  bit m_wrap [2];

  always #5 clk = ~clk;

  led_pattern_gen #(.WIDTH(4), .DIV(3), .CNT_W(2)) u_dut_div3 (
    .CLK(clk), .RST(rst_n), .EN(en), .MODE(mode), .DIR(dir), .LOAD(load),
    .LOAD_VAL(load_val), .LED(led_a), .TICK(tick_a), .WRAP(wrap_a)
  );

  led_pattern_gen #(.WIDTH(4), .DIV(1), .CNT_W(1)) u_dut_div1 (
    .CLK(clk), .RST(rst_n), .EN(en), .MODE(mode), .DIR(dir), .LOAD(load),
    .LOAD_VAL(load_val), .LED(led_b), .TICK(tick_b), .WRAP(wrap_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_led[i] = 0; m_cnt[i] = 0; m_mode[i] = 0;
      m_up[i] = 1'b1; m_tick[i] = 1'b0; m_wrap[i] = 1'b0;
    end
  endtask

  task automatic pattern_step(input int i);
    int v;
    v = m_led[i];
    m_wrap[i] = 1'b0;
    case (m_mode[i])
      0: begin
        if (!dir) v = (v * 2) % 16 + ((v >= 8) ? 0 : 1);
        else      v = v / 2 + ((v % 2 == 1) ? 0 : 8);
        m_wrap[i] = (v == 0);
      end
      1: begin
        if (!dir) begin m_wrap[i] = (v >= 8);     v = (v * 2) % 16 + ((v >= 8) ? 1 : 0); end
        else      begin m_wrap[i] = (v % 2 == 1); v = v / 2 + ((v % 2 == 1) ? 8 : 0); end
      end
      3: begin
        if (!dir) begin m_wrap[i] = (v == 15); v = (v + 1) % 16;  end
        else      begin m_wrap[i] = (v == 0);  v = (v + 15) % 16; end
      end
      default: begin
        if (v == 0) begin
          v = 1; m_up[i] = 1'b1;
        end else if (m_up[i]) begin
          if (v >= 8) begin v = v / 2; m_up[i] = 1'b0; end
          else v = v * 2;
        end else begin
          if (v % 2 == 1) begin v = (v * 2) % 16; m_up[i] = 1'b1; m_wrap[i] = 1'b1; end
          else v = v / 2;
        end
      end
    endcase
    m_led[i] = v;
  endtask

  task automatic model_update(input int i);
    int d;
    d = (i == 0) ? 3 : 1;
    m_tick[i] = 1'b0;
    m_wrap[i] = 1'b0;
    if (load) begin
      m_led[i] = load_val; m_cnt[i] = 0; m_up[i] = !dir; m_mode[i] = mode;
    end else if (int'(mode) != m_mode[i]) begin
      m_mode[i] = mode; m_cnt[i] = 0; m_up[i] = !dir;
      case (mode)
        2'd1:    m_led[i] = 1;
        2'd2:    m_led[i] = dir ? 8 : 1;
        default: m_led[i] = 0;
      endcase
    end else if (en) begin
      if (m_cnt[i] == d - 1) begin
        m_cnt[i] = 0;
        m_tick[i] = 1'b1;
        pattern_step(i);
      end else begin
        m_cnt[i]++;
      end
    end
  endtask

  task automatic check_outputs();
    check("div3.led",  {28'd0, led_a}, m_led[0]);
    check("div3.tick", {31'd0, tick_a}, {31'd0, m_tick[0]});
    check("div3.wrap", {31'd0, wrap_a}, {31'd0, m_wrap[0]});
    check("div1.led",  {28'd0, led_b}, m_led[1]);
    check("div1.tick", {31'd0, tick_b}, {31'd0, m_tick[1]});
    check("div1.wrap", {31'd0, wrap_b}, {31'd0, m_wrap[1]});
  endtask

  // inputs are set by the caller just after a falling edge
  task automatic cycle();
    model_update(0);
    model_update(1);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // asserts reset between edges and checks the immediate clear
  task automatic async_reset(input int hold);
    #2 rst_n = 1'b0;
    #1;
    check("rst.led_a",  {28'd0, led_a}, 32'd0);
    check("rst.tick_a", {31'd0, tick_a}, 32'd0);
    check("rst.wrap_a", {31'd0, wrap_a}, 32'd0);
    check("rst.led_b",  {28'd0, led_b}, 32'd0);
    check("rst.tick_b", {31'd0, tick_b}, 32'd0);
    model_reset();
    for (int k = 0; k < hold; k++) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'd0; dir = 1'b0; load = 1'b0; load_val = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset.led",  {28'd0, led_a}, 32'd0);
    check("reset.tick", {31'd0, tick_a}, 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;

    // Johnson fill, full period plus a bit
    run(30);

    // ping-pong from its seed
    mode = 2'd2; dir = 1'b0;
    run(30);

    // down-counter from a loaded 0001
    mode = 2'd3; dir = 1'b1; load = 1'b1; load_val = 4'b0001;
    cycle();
    load = 1'b0;
    run(12);

    // EN held low mid-count, with a load while paused
    mode = 2'd0; dir = 1'b0;
    run(4);
    en = 1'b0;
    run(5);
    load = 1'b1; load_val = 4'b1010;
    cycle();
    load = 1'b0;
    run(2);
    en = 1'b1;
    run(10);

    // load on the edge where the DIV=3 step is due
    for (int k = 0; k < 5 && m_cnt[0] != 2; k++) cycle();
    load = 1'b1; load_val = 4'b0110;
    cycle();
    load = 1'b0;
    run(8);

    // reset mid-sequence in ping-pong
    mode = 2'd2; dir = 1'b1;
    run(7);
    async_reset(2);
    run(12);

    // randomized
    for (int k = 0; k < 3000; k++) begin
      en   = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 29) == 0);
      load_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) dir = ~dir;
      if ($urandom_range(0, 499) == 0) async_reset(1);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
